// File: rtl/alu_param_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
// Opcode constants double as the encodings of alu_op_e.
package alu_param_pkg;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_MUL = 3'b010;
    localparam logic [2:0] OPC_SHL = 3'b011;
    localparam logic [2:0] OPC_SHR = 3'b100;
    localparam logic [2:0] OPC_AND = 3'b101;
    localparam logic [2:0] OPC_OR  = 3'b110;
    localparam logic [2:0] OPC_XOR = 3'b111;

    typedef enum logic [2:0] {
        OP_ADD = OPC_ADD,
        OP_SUB = OPC_SUB,
        OP_MUL = OPC_MUL,
        OP_SHL = OPC_SHL,
        OP_SHR = OPC_SHR,
        OP_AND = OPC_AND,
        OP_OR  = OPC_OR,
        OP_XOR = OPC_XOR
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_param_mul.sv
// Shift-add multiplier: one partial product per cycle, WIDTH steps.
// done pulses for one cycle once all steps are accumulated.
module alu_param_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    import alu_param_pkg::*;

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [W2-1:0]    mcand;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;

    assign done = busy && (cnt == CW'(WIDTH));
    assign prod = acc;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= W2'(a);
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_param_seq.sv
// Handshaked ALU: IDLE -> (MUL) -> DONE, results held until taken.
// Define ALU_ITER_MUL_EN for the iterative multiplier (else single-cycle).
module alu_param_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   InputA,
    input  logic [WIDTH-1:0]   InputB,
    input  logic [2:0]         OpCode,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [2*WIDTH-1:0] OutALU,
    output logic               OutZero,
    output logic               OutCarry
);
    import alu_param_pkg::*;

    localparam int W2 = 2 * WIDTH;

    alu_state_e       state, nextState;
    logic [WIDTH-1:0] regA, regB;
    alu_op_e          regOp;
    logic             accept, isMul, isDone;
    logic             mulDone;
    logic [W2-1:0]    mulProd, aExt, bExt, res;
    logic [SHW-1:0]   shamt;
    logic             carry;

    assign InReady = (state == S_IDLE);
    assign accept  = InValid && InReady;
    assign isMul   = (OpCode == OPC_MUL);
    assign aExt    = W2'(regA);
    assign bExt    = W2'(regB);
    assign shamt   = regB[SHW-1:0];

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            regA  <= '0;
            regB  <= '0;
            regOp <= OP_ADD;
        end else if (accept) begin
            regA  <= InputA;
            regB  <= InputB;
            regOp <= alu_op_e'(OpCode);
        end
    end

`ifdef ALU_ITER_MUL_EN
    localparam logic ITER_MUL = 1'b1;
    logic mulStart;
    assign mulStart = accept && isMul;

    alu_param_mul #(.WIDTH(WIDTH)) uMul (
        .clk  (Clk),
        .rstN (RstN),
        .start(mulStart),
        .a    (InputA),
        .b    (InputB),
        .done (mulDone),
        .prod (mulProd)
    );
`else
    localparam logic ITER_MUL = 1'b0;
    assign mulDone = 1'b0;
    assign mulProd = aExt * bExt;
`endif

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) state <= S_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            S_IDLE: if (accept)
                nextState = (isMul && ITER_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mulDone) nextState = S_DONE;
            S_DONE: if (OutReady) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // Operand registers are frozen outside IDLE, so res is stable in DONE
    always_comb begin
        res   = '0;
        carry = 1'b0;
        unique case (regOp)
            OP_ADD: begin
                res   = aExt + bExt;
                carry = res[WIDTH];
            end
            OP_SUB: begin
                res   = aExt - bExt;
                carry = (regA < regB);
            end
            OP_MUL: res = mulProd;
            OP_SHL: res = aExt << shamt;
            OP_SHR: res = aExt >> shamt;
            OP_AND: res = aExt & bExt;
            OP_OR:  res = aExt | bExt;
            OP_XOR: res = aExt ^ bExt;
            default: res = '0;
        endcase
    end

    assign isDone   = (state == S_DONE);
    assign OutValid = isDone;
    assign OutALU   = isDone ? res : '0;
    assign OutZero  = isDone && (res == '0);
    assign OutCarry = isDone && carry;

endmodule
